filtro_iir_cascada: RTL and testbench
=====================================

FILTRO_IIR_CASCADA -- requirements
Module: filtro_iir_cascada

Interface
REQ-001 SHALL have parameter N, default 25: sample and coefficient width, two's complement.
REQ-002 SHALL have parameter FRAC, default 20: fractional bits of coefficients (Q(N-FRAC).FRAC).
REQ-003 SHALL have parameter SECCIONES, default 1: number of cascaded second-order sections, range 1..8.
REQ-004 SHALL have port Clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port Rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port Uk, input, N: input sample.
REQ-007 SHALL have port Bandera_ADC, input, 1: one-cycle strobe, Uk valid.
REQ-008 SHALL have ports Coef_We (input, 1), Coef_Addr (input, clog2(5*SECCIONES)) and Coef_Data (input, N): coefficient write port.
REQ-009 SHALL have port Yk, output, N: filtered sample, held between updates.
REQ-010 SHALL have port Bandera_Listo, output, 1: one-cycle pulse, new Yk valid.
REQ-011 SHALL have port Overrun, output, 1: sticky flag, sample dropped.

Function
REQ-012 Each section SHALL compute Direct Form I: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2; the output of section s SHALL be the input of section s+1.
REQ-013 Coefficient address SHALL be 5*s+k, where k=0 b0, 1 b1, 2 b2, 3 a1, 4 a2; addresses >= 5*SECCIONES SHALL be ignored.
REQ-014 SHALL use one time-multiplexed multiplier, one product per cycle.
REQ-015 FSM states SHALL be IDLE, MAC, REDONDEO, LISTO.
- IDLE -> MAC on Bandera_ADC, with Uk captured.
- MAC runs 5*SECCIONES cycles, with an intermediate round at each section boundary.
- REDONDEO takes 1 cycle.
- LISTO takes 1 cycle, then -> IDLE.
REQ-016 Latency from the Bandera_ADC cycle to the Bandera_Listo cycle SHALL be exactly 5*SECCIONES+2 clocks.
REQ-017 Accumulator width SHALL be 2N+3; each section result SHALL be rounded half-up at bit FRAC and reduced to N bits per REQ-025/026.
REQ-018 Delay lines (x1, x2, y1, y2 per section) SHALL update only at the LISTO cycle, using the reduced N-bit values.
REQ-019 Yk SHALL update at the LISTO cycle, with Bandera_Listo high that same cycle.
REQ-020 Bandera_ADC while not IDLE SHALL drop the sample and set Overrun; the computation in progress SHALL be unaffected.
REQ-021 Bandera_ADC in the LISTO cycle SHALL count as busy, not as accepted.
REQ-022 Coef_We while not IDLE SHALL be ignored and SHALL set Overrun; Coef_We in IDLE SHALL write in one cycle.
REQ-023 Coef_We and Bandera_ADC together in IDLE SHALL write the coefficient first; the sample SHALL use the new coefficient.
REQ-024 Overrun SHALL clear only on reset.

Configuration
REQ-025 With FILTRO_SAT_EN defined, section results SHALL saturate to [-2^(N-1), 2^(N-1)-1].
REQ-026 Without FILTRO_SAT_EN, section results SHALL wrap (keep the low N bits after rounding).

Reset
REQ-027 With Rst_n low at a rising edge, the following SHALL reset:
- FSM -> IDLE.
- Yk, all delay lines, the accumulator -> 0.
- Bandera_Listo, Overrun -> 0.
- Coefficients -> identity: b0 = 2^FRAC, all others 0.
REQ-028 Reset mid-computation SHALL abort it with no Bandera_Listo pulse.
REQ-029 The first sample after reset SHALL be processed normally.

Structure
REQ-030 Package filtro_pkg SHALL hold:
- FSM state enum;
- coefficient index constants B0..A2;
- a function for accumulator width;
- a function for coefficient address width.
REQ-031 The multiply-accumulate, round and reduce datapath SHALL be sub-module filtro_mac; the FSM, coefficient RAM and delay lines SHALL stay in filtro_iir_cascada.

Verification (N=25, FRAC=20, SECCIONES=1 unless stated)
REQ-032 Identity: after reset, Uk=1000 with strobe -> Yk=1000 and Bandera_Listo exactly 7 cycles later; Overrun=0.
REQ-033 FIR: b0=b1=b2=262144 (0.25), a=0; impulse 1000 then zeros -> Yk 250, 250, 250, 0.
REQ-034 IIR: b0=1048576, a1=-524288 (-0.5); impulse 1024 -> Yk 1024, 512, 256, 128.
REQ-035 Saturation: b0=0x7FFFFF (~7.99), Uk=0x7FFFFF -> Yk=0x0FFFFFF with FILTRO_SAT_EN; wrapped value without it.
REQ-036 Overrun/reset: second strobe 3 cycles after the first -> one Listo, Overrun=1; Rst_n low at cycle 4 of a computation -> no Listo, Yk=0, Overrun=0.
REQ-037 SECCIONES=2, both sections identity: Uk=-5000 -> Yk=-5000 after 12 cycles.

Source files
------------

// File: rtl/filtro_pkg.sv
// Shared types and sizing helpers for the cascaded biquad IIR filter.
// Holds the FSM state enum, coefficient slot indices and width functions.
package filtro_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        REDONDEO,
        LISTO
    } estado_t;

    // Slot of each coefficient inside a section's five-entry block
    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

    localparam int COEFS_POR_SECCION = 5;

    function automatic int acc_width(input int n);
        return 2 * n + 3;
    endfunction

    function automatic int coef_addr_width(input int secciones);
        return $clog2(COEFS_POR_SECCION * secciones);
    endfunction

endpackage

// File: rtl/filtro_mac.sv
// Shared multiply-accumulate, half-up rounding at bit FRAC and reduction to N bits.
// FILTRO_SAT_EN selects saturation of the reduced result; otherwise it wraps.
module filtro_mac
    import filtro_pkg::*;
#(
    parameter int N    = 25,
    parameter int FRAC = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                resta,
    input  logic signed [N-1:0] coef,
    input  logic signed [N-1:0] dato,
    output logic signed [N-1:0] resultado
);

    localparam int AW = acc_width(N);
    localparam logic signed [AW-1:0] MEDIO   = AW'(64'd1 << (FRAC - 1));
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [2*N-1:0] prod;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  acc_next;
    logic signed [AW-1:0]  redondeado;

    assign prod = coef * dato;

    // The reduced value sees the product of the current cycle, so a section
    // can be closed in the same cycle as its last multiply.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        prod_ext   = AW'(prod);
        acc_next   = acc;
        if (en) begin
            acc_next = resta ? acc - prod_ext : acc + prod_ext;
        end
        redondeado = (acc_next + MEDIO) >>> FRAC;
`ifdef FILTRO_SAT_EN
        if (redondeado > SAT_MAX) begin
            resultado = SAT_MAX[N-1:0];
        end else if (redondeado < SAT_MIN) begin
            resultado = SAT_MIN[N-1:0];
        end else begin
            resultado = redondeado[N-1:0];
        end
`else
        resultado = redondeado[N-1:0];
`endif
    end

`ifndef FILTRO_SAT_EN
    logic unused_bits;
    assign unused_bits = ^redondeado[AW-1:N];
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/filtro_iir_cascada.sv
// Cascade of SECCIONES Direct Form I biquads sharing one multiplier.
// Build option FILTRO_SAT_EN: saturate section results instead of wrapping.
module filtro_iir_cascada
    import filtro_pkg::*;
#(
    parameter int N         = 25,
    parameter int FRAC      = 20,
    parameter int SECCIONES = 1
) (
    input  logic                                     Clk,
    input  logic                                     Rst_n,
    input  logic signed [N-1:0]                      Uk,
    input  logic                                     Bandera_ADC,
    input  logic                                     Coef_We,
    input  logic [coef_addr_width(SECCIONES)-1:0]    Coef_Addr,
    input  logic signed [N-1:0]                      Coef_Data,
    output logic signed [N-1:0]                      Yk,
    output logic                                     Bandera_Listo,
    output logic                                     Overrun
);

    localparam int AW    = coef_addr_width(SECCIONES);
    localparam int NCOEF = COEFS_POR_SECCION * SECCIONES;
    localparam int SW    = (SECCIONES > 1) ? $clog2(SECCIONES) : 1;
    localparam int NSEC  = 2 ** SW;
    localparam logic [SW-1:0]       ULTIMA = SW'(SECCIONES - 1);
    localparam logic signed [N-1:0] UNO    = N'(64'd1 << FRAC);

    estado_t state_q, state_d;
    logic [2:0]    k_q;
    logic [SW-1:0] sec_q;
    logic signed [N-1:0] u_cap;

    logic signed [N-1:0] coef_mem [0:2**AW-1];
    logic signed [N-1:0] x1_q [0:NSEC-1];
    logic signed [N-1:0] x2_q [0:NSEC-1];
    logic signed [N-1:0] y1_q [0:NSEC-1];
    logic signed [N-1:0] y2_q [0:NSEC-1];
    logic signed [N-1:0] sec_y [0:NSEC-1];
    logic signed [N-1:0] x_cur [0:NSEC-1];

    logic mac_en, mac_clr, captura, fin_seccion, resta;
    logic [AW-1:0]       coef_idx;
    logic signed [N-1:0] coef_sel, dato, mac_res;

    always_comb begin
        state_d     = state_q;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        captura     = 1'b0;
        fin_seccion = 1'b0;
        case (state_q)
            IDLE: begin
                if (Bandera_ADC) begin
                    state_d = MAC;
                    captura = 1'b1;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k_q == A2) begin
                    if (sec_q == ULTIMA) begin
                        state_d = REDONDEO;
                    end else begin
                        mac_clr     = 1'b1;
                        fin_seccion = 1'b1;
                    end
                end
            end
            REDONDEO: begin
                mac_clr = 1'b1;
                state_d = LISTO;
            end
            LISTO:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Section 0 reads the captured sample; later sections read the previous result
    always_comb begin
        x_cur[0] = u_cap;
        for (int s = 1; s < NSEC; s++) begin
            x_cur[s] = sec_y[s-1];
        end
        coef_idx = AW'(COEFS_POR_SECCION * int'(sec_q) + int'(k_q));
        coef_sel = coef_mem[coef_idx];
        resta    = (k_q == A1) || (k_q == A2);
        case (k_q)
            B0:      dato = x_cur[sec_q];
            B1:      dato = x1_q[sec_q];
            B2:      dato = x2_q[sec_q];
            A1:      dato = y1_q[sec_q];
            default: dato = y2_q[sec_q];
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            sec_q   <= '0;
            u_cap   <= '0;
            Overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (captura) begin
                u_cap <= Uk;
            end
            if (state_q == MAC) begin
                if (k_q == A2) begin
                    k_q   <= B0;
                    sec_q <= sec_q + 1'b1;
                end else begin
                    k_q <= k_q + 3'd1;
                end
            end else begin
                k_q   <= B0;
                sec_q <= '0;
            end
            if (state_q != IDLE && (Bandera_ADC || Coef_We)) begin
                Overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: the coefficient store is reset to the identity filter, so it is built from flops, not a RAM macro.
        if (!Rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                coef_mem[i] <= (i < NCOEF && i % COEFS_POR_SECCION == 0) ? UNO : '0;
            end
        end else if (state_q == IDLE && Coef_We && int'(Coef_Addr) < NCOEF) begin
            coef_mem[Coef_Addr] <= Coef_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int s = 0; s < NSEC; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else if (state_q == LISTO) begin
            for (int s = 0; s < SECCIONES; s++) begin
                x2_q[s] <= x1_q[s];
                x1_q[s] <= x_cur[s];
                y2_q[s] <= y1_q[s];
                y1_q[s] <= sec_y[s];
            end
        end
    end

    // Yk is loaded on the edge into LISTO so it is valid while Bandera_Listo is high
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Yk            <= '0;
            Bandera_Listo <= 1'b0;
            for (int s = 0; s < NSEC; s++) begin
                sec_y[s] <= '0;
            end
        end else begin
            Bandera_Listo <= (state_q == REDONDEO);
            if (fin_seccion) begin
                sec_y[sec_q] <= mac_res;
            end
            if (state_q == REDONDEO) begin
                sec_y[ULTIMA] <= mac_res;
                Yk            <= mac_res;
            end
        end
    end

    filtro_mac #(
        .N    (N),
        .FRAC (FRAC)
    ) u_mac (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .en        (mac_en),
        .clr       (mac_clr),
        .resta     (resta),
        .coef      (coef_sel),
        .dato      (dato),
        .resultado (mac_res)
    );

endmodule

// File: tb/tb_filtro_iir_cascada.sv
// Self-checking bench: one-section and two-section filters against an arithmetic model.
// Expected saturation results follow FILTRO_SAT_EN when defined.
module tb_filtro_iir_cascada;

    localparam int N    = 25;
    localparam int FRAC = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic signed [N-1:0] uk1, data1, yk1;
    logic                adc1, we1, listo1, ovr1;
    logic [2:0]          addr1;
    logic signed [N-1:0] uk2, data2, yk2;
    logic                adc2, we2, listo2, ovr2;
    logic [3:0]          addr2;

    int checks = 0;
    int errors = 0;

    // Model state: [instance][coefficient or section]
    longint mc  [2][40];
    longint mx1 [2][8];
    longint mx2 [2][8];
    longint my1 [2][8];
    longint my2 [2][8];

    always #5 clk = ~clk;

    filtro_iir_cascada #(.N(N), .FRAC(FRAC), .SECCIONES(1)) dut (
        .Clk(clk), .Rst_n(rst_n), .Uk(uk1), .Bandera_ADC(adc1),
        .Coef_We(we1), .Coef_Addr(addr1), .Coef_Data(data1),
        .Yk(yk1), .Bandera_Listo(listo1), .Overrun(ovr1)
    );

    filtro_iir_cascada #(.N(N), .FRAC(FRAC), .SECCIONES(2)) dut2 (
        .Clk(clk), .Rst_n(rst_n), .Uk(uk2), .Bandera_ADC(adc2),
        .Coef_We(we2), .Coef_Addr(addr2), .Coef_Data(data2),
        .Yk(yk2), .Bandera_Listo(listo2), .Overrun(ovr2)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nsec(input int inst);
        return (inst == 0) ? 1 : 2;
    endfunction

    function automatic longint reduce(input longint r);
`ifdef FILTRO_SAT_EN
        if (r > (longint'(1) <<< (N-1)) - 1) return (longint'(1) <<< (N-1)) - 1;
        if (r < -(longint'(1) <<< (N-1)))    return -(longint'(1) <<< (N-1));
        return r;
`else
        longint w;
        w = r & ((longint'(1) <<< N) - 1);
        if (w >= (longint'(1) <<< (N-1))) w = w - (longint'(1) <<< N);
        return w;
`endif
    endfunction

    task automatic model_reset(input int inst);
        for (int i = 0; i < 40; i++) mc[inst][i] = (i % 5 == 0) ? (longint'(1) <<< FRAC) : 0;
        for (int s = 0; s < 8; s++) begin
            mx1[inst][s] = 0; mx2[inst][s] = 0; my1[inst][s] = 0; my2[inst][s] = 0;
        end
    endtask

    task automatic model_step(input int inst, input longint u, output longint y);
        longint x, acc, r;
        x = u;
        y = 0;
        for (int s = 0; s < nsec(inst); s++) begin
            acc = mc[inst][5*s] * x + mc[inst][5*s+1] * mx1[inst][s] + mc[inst][5*s+2] * mx2[inst][s]
                - mc[inst][5*s+3] * my1[inst][s] - mc[inst][5*s+4] * my2[inst][s];
            r = (acc + (longint'(1) <<< (FRAC-1))) >>> FRAC;
            y = reduce(r);
            mx2[inst][s] = mx1[inst][s]; mx1[inst][s] = x;
            my2[inst][s] = my1[inst][s]; my1[inst][s] = y;
            x = y;
        end
    endtask

    task automatic model_write(input int inst, input int a, input longint d);
        logic signed [N-1:0] t;
        t = N'(d);
        if (a < 5 * nsec(inst)) mc[inst][a] = longint'(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        adc1 = 1'b0; we1 = 1'b0; adc2 = 1'b0; we2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(0);
        model_reset(1);
    endtask

    task automatic wr(input int inst, input int a, input longint d);
        @(negedge clk);
        if (inst == 0) begin we1 = 1'b1; addr1 = 3'(a); data1 = N'(d); end
        else           begin we2 = 1'b1; addr2 = 4'(a); data2 = N'(d); end
        model_write(inst, a, d);
        @(negedge clk);
        we1 = 1'b0; we2 = 1'b0;
    endtask

    // Called right after the strobe was driven; waits for the ready pulse.
    task automatic finish(input int inst, input string tag, output logic signed [N-1:0] y_obs);
        int lat;
        @(negedge clk);
        adc1 = 1'b0; adc2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
        lat = 1;
        while (((inst == 0) ? listo1 : listo2) !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 5 * nsec(inst) + 2);
        y_obs = (inst == 0) ? yk1 : yk2;
    endtask

    task automatic run(input int inst, input longint u, input string tag,
                       output logic signed [N-1:0] y_obs, output longint y_mod);
        @(negedge clk);
        if (inst == 0) begin uk1 = N'(u); adc1 = 1'b1; end
        else           begin uk2 = N'(u); adc2 = 1'b1; end
        model_step(inst, u, y_mod);
        finish(inst, tag, y_obs);
    endtask

    function automatic longint rnd_coef();
        return longint'($urandom_range(0, 2**21)) - (longint'(1) <<< 20);
    endfunction

    function automatic longint rnd_sample();
        return longint'($urandom_range(0, 2**N - 1)) - (longint'(1) <<< (N-1));
    endfunction

    initial begin
        logic signed [N-1:0] yo;
        longint ym, sat_exp;
        int pulses;
        longint fir_exp [4];
        longint iir_exp [4];
        fir_exp = '{250, 250, 250, 0};
        iir_exp = '{1024, 512, 256, 128};

        uk1 = '0; data1 = '0; adc1 = 1'b0; we1 = 1'b0; addr1 = '0;
        uk2 = '0; data2 = '0; adc2 = 1'b0; we2 = 1'b0; addr2 = '0;

        // Reset state of both instances
        do_reset();
        @(negedge clk);
        check("rst yk1", yk1, 0);
        check("rst listo1", listo1, 0);
        check("rst ovr1", ovr1, 0);
        check("rst yk2", yk2, 0);
        check("rst listo2", listo2, 0);
        check("rst ovr2", ovr2, 0);

        // Identity coefficients after reset
        run(0, 1000, "ident", yo, ym);
        check("ident yk", yo, 1000);
        check("ident ovr", ovr1, 0);
        @(negedge clk);
        check("listo one cycle", listo1, 0);

        // FIR impulse response
        do_reset();
        wr(0, 0, 262144); wr(0, 1, 262144); wr(0, 2, 262144);
        for (int i = 0; i < 4; i++) begin
            run(0, (i == 0) ? 1000 : 0, "fir", yo, ym);
            check("fir yk", yo, fir_exp[i]);
        end

        // IIR impulse response with a1 = -0.5
        do_reset();
        wr(0, 0, 1048576); wr(0, 3, -524288);
        for (int i = 0; i < 4; i++) begin
            run(0, (i == 0) ? 1024 : 0, "iir", yo, ym);
            check("iir yk", yo, iir_exp[i]);
        end

        // Out-of-range result: saturate or wrap
        do_reset();
        wr(0, 0, 25'h7FFFFF);
`ifdef FILTRO_SAT_EN
        sat_exp = 25'h0FFFFFF;
`else
        sat_exp = -16;
`endif
        run(0, 25'h7FFFFF, "sat", yo, ym);
        check("sat yk", yo, sat_exp);

        // Second strobe and a coefficient write while busy are dropped
        do_reset();
        @(negedge clk); uk1 = 4321; adc1 = 1'b1;
        model_step(0, 4321, ym);
        @(negedge clk); adc1 = 1'b0;
        @(negedge clk); we1 = 1'b1; addr1 = 3'd0; data1 = '0;
        @(negedge clk); we1 = 1'b0; uk1 = 999; adc1 = 1'b1;
        @(negedge clk); adc1 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (listo1 === 1'b1) begin pulses++; yo = yk1; end
            @(negedge clk);
        end
        check("ovr pulses", pulses, 1);
        check("ovr yk", yo, ym);
        check("ovr flag", ovr1, 1);
        run(0, 555, "after ovr", yo, ym);
        check("after ovr yk", yo, ym);
        check("ovr sticky", ovr1, 1);

        // Strobe during the ready cycle counts as busy
        do_reset();
        run(0, 100, "listo busy", yo, ym);
        uk1 = 200; adc1 = 1'b1;
        @(negedge clk); adc1 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (listo1 === 1'b1) pulses++;
            @(negedge clk);
        end
        check("listo busy pulses", pulses, 0);
        check("listo busy ovr", ovr1, 1);
        check("listo busy yk", yk1, 100);

        // Reset in the middle of a computation
        do_reset();
        run(0, 777, "pre rst", yo, ym);
        check("pre rst yk", yo, 777);
        @(negedge clk); uk1 = 888; adc1 = 1'b1;
        @(negedge clk); adc1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset(0); model_reset(1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (listo1 === 1'b1) pulses++;
            @(negedge clk);
        end
        check("mid rst pulses", pulses, 0);
        check("mid rst yk", yk1, 0);
        check("mid rst ovr", ovr1, 0);
        run(0, 321, "post rst", yo, ym);
        check("post rst yk", yo, 321);

        // Coefficient write and strobe in the same cycle
        @(negedge clk);
        we1 = 1'b1; addr1 = 3'd0; data1 = 25'sd2097152; uk1 = 300; adc1 = 1'b1;
        model_write(0, 0, 2097152);
        model_step(0, 300, ym);
        finish(0, "wr+adc", yo);
        check("wr+adc yk", yo, 600);
        check("wr+adc model", yo, ym);

        // Random coefficients (including unmapped addresses) and samples
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 2) == 0) wr(0, int'($urandom_range(0, 7)), rnd_coef());
            run(0, rnd_sample(), "rnd1", yo, ym);
            check("rnd1 yk", yo, ym);
        end

        // Two sections
        do_reset();
        run(1, -5000, "cascade ident", yo, ym);
        check("cascade ident yk", yo, -5000);
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 0) wr(1, int'($urandom_range(0, 15)), rnd_coef());
            run(1, rnd_sample(), "rnd2", yo, ym);
            check("rnd2 yk", yo, ym);
        end
        check("cascade ovr", ovr2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
